// File: rtl/atmega_icp_8bit_pkg.sv
// Shared definitions for the 8-bit input-capture timer: register bit positions,
// default IO addresses and the prescaler select encoding used by the 8-bit timers.
package atmega_icp_8bit_pkg;

    localparam logic [7:0] ICCR_ADDR_DEF  = 8'h50;
    localparam logic [7:0] ICNT_ADDR_DEF  = 8'h51;
    localparam logic [7:0] ICR_ADDR_DEF   = 8'h52;
    localparam logic [7:0] ICIFR_ADDR_DEF = 8'h53;
    localparam logic [7:0] ICMSK_ADDR_DEF = 8'h54;

    localparam int ICCR_ICCTC = 3;
    localparam int ICCR_ICES  = 6;
    localparam int ICCR_ICNC  = 7;

    // ICCR write mask: bit positions 5 and 4 are reserved and read back as zero
    localparam logic [7:0] ICCR_WMASK = 8'hCF;

    localparam int ICIFR_ICF = 0;
    localparam int ICIFR_TOV = 1;
    localparam int ICIFR_OVR = 2;

    localparam int ICMSK_ICIE = 0;
    localparam int ICMSK_TOIE = 1;

    typedef enum logic [2:0] {
        CS_STOP    = 3'b000,
        CS_CLK1    = 3'b001,
        CS_CLK8    = 3'b010,
        CS_CLK64   = 3'b011,
        CS_CLK256  = 3'b100,
        CS_CLK1024 = 3'b101,
        CS_RSVD6   = 3'b110,
        CS_RSVD7   = 3'b111
    } cs_sel_t;

endpackage

// File: rtl/atmega_icp_8bit_filter.sv
// Capture pin front end: two-flop synchronizer, optional noise canceller that
// needs NC_DEPTH equal samples before following the pin, and a one-flop edge
// history producing a single-cycle capture pulse on the selected polarity.
module atmega_icp_filter
    import atmega_icp_8bit_pkg::*;
#(
    parameter int NC_DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    input  logic nc_en_i,
    input  logic edge_sel_i,
    output logic capture_o
);

    localparam logic [3:0] NC_LAST = 4'(NC_DEPTH - 1);

    logic       sync1;
    logic       sync2;
    logic       filt_q;
    logic [3:0] nc_cnt;
    logic       hist;
    logic       nc_en_q;
    logic       edge_sel_q;
    logic       filtered;
    logic       cfg_change;

    assign filtered   = nc_en_i ? filt_q : sync2;
    // A mode or polarity change only reloads the history, it never reports an edge
    assign cfg_change = (nc_en_i != nc_en_q) || (edge_sel_i != edge_sel_q);
    assign capture_o  = !cfg_change && (filtered != hist) && (filtered == edge_sel_i);

    // Synchronize the pin, run the canceller continuously, and track edge history
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            filt_q     <= 1'b0;
            nc_cnt     <= 4'd0;
            hist       <= 1'b0;
            nc_en_q    <= 1'b0;
            edge_sel_q <= 1'b0;
        end else begin
            sync1 <= pin_i;
            sync2 <= sync1;
            if (sync2 == filt_q) begin
                nc_cnt <= 4'd0;
            end else if (nc_cnt == NC_LAST) begin
                filt_q <= sync2;
                nc_cnt <= 4'd0;
            end else begin
                nc_cnt <= nc_cnt + 4'd1;
            end
            hist       <= filtered;
            nc_en_q    <= nc_en_i;
            edge_sel_q <= edge_sel_i;
        end
    end

endmodule

// File: rtl/atmega_icp_8bit.sv
// ATmega-style 8-bit input-capture timer: prescaled free-running counter,
// capture register with overrun detection, interrupt flags and IO bus decode.
module atmega_icp_8bit
    import atmega_icp_8bit_pkg::*;
#(
    parameter int BUS_ADDR_DATA_LEN = 8,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] ICCR_ADDR  = BUS_ADDR_DATA_LEN'(ICCR_ADDR_DEF),
    parameter logic [BUS_ADDR_DATA_LEN-1:0] ICNT_ADDR  = BUS_ADDR_DATA_LEN'(ICNT_ADDR_DEF),
    parameter logic [BUS_ADDR_DATA_LEN-1:0] ICR_ADDR   = BUS_ADDR_DATA_LEN'(ICR_ADDR_DEF),
    parameter logic [BUS_ADDR_DATA_LEN-1:0] ICIFR_ADDR = BUS_ADDR_DATA_LEN'(ICIFR_ADDR_DEF),
    parameter logic [BUS_ADDR_DATA_LEN-1:0] ICMSK_ADDR = BUS_ADDR_DATA_LEN'(ICMSK_ADDR_DEF),
    parameter int NC_DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clk8_i,
    input  logic                         clk64_i,
    input  logic                         clk256_i,
    input  logic                         clk1024_i,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr_i,
    input  logic                         wr_i,
    input  logic                         rd_i,
    input  logic [7:0]                   bus_i,
    output logic [7:0]                   bus_o,
    output logic                         icp_int_o,
    input  logic                         icp_int_ack_i,
    output logic                         tov_int_o,
    input  logic                         tov_int_ack_i,
    input  logic                         icp_i
);

    logic [7:0] iccr;
    logic [7:0] icnt;
    logic [7:0] icr;
    logic [1:0] icmsk;
    logic       icf;
    logic       tov;
    logic       ovr;
    logic [3:0] presc_q;
    logic [3:0] presc_rise;
    logic       count_tick;
    logic       capture;
    logic       ctc_clear;
    logic       wr_iccr;
    logic       wr_icnt;
    logic       wr_icifr;
    logic       wr_icmsk;
    logic       icf_set;
    logic       icf_clr;
    logic       tov_set;
    logic       tov_clr;
    logic       ovr_set;
    logic       ovr_clr;

    assign wr_iccr  = wr_i && (addr_i == ICCR_ADDR);
    assign wr_icnt  = wr_i && (addr_i == ICNT_ADDR);
    assign wr_icifr = wr_i && (addr_i == ICIFR_ADDR);
    assign wr_icmsk = wr_i && (addr_i == ICMSK_ADDR);

    assign presc_rise = {clk1024_i, clk256_i, clk64_i, clk8_i} & ~presc_q;
    assign ctc_clear  = capture && iccr[ICCR_ICCTC];

    assign icf_set = capture;
    assign icf_clr = icp_int_ack_i || (wr_icifr && bus_i[ICIFR_ICF]);
    assign tov_set = count_tick && (icnt == 8'hFF) && !wr_icnt && !ctc_clear;
    assign tov_clr = tov_int_ack_i || (wr_icifr && bus_i[ICIFR_TOV]);
    assign ovr_set = capture && icf;
    assign ovr_clr = wr_icifr && bus_i[ICIFR_OVR];

    assign icp_int_o = icf && icmsk[ICMSK_ICIE];
    assign tov_int_o = tov && icmsk[ICMSK_TOIE];

    atmega_icp_filter #(
        .NC_DEPTH (NC_DEPTH)
    ) u_filter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .pin_i      (icp_i),
        .nc_en_i    (iccr[ICCR_ICNC]),
        .edge_sel_i (iccr[ICCR_ICES]),
        .capture_o  (capture)
    );

    // Select the counter advance source from the clock-select field
    always_comb begin
        count_tick = 1'b0;
        case (cs_sel_t'(iccr[2:0]))
            CS_CLK1:    count_tick = 1'b1;
            CS_CLK8:    count_tick = presc_rise[0];
            CS_CLK64:   count_tick = presc_rise[1];
            CS_CLK256:  count_tick = presc_rise[2];
            CS_CLK1024: count_tick = presc_rise[3];
            default:    count_tick = 1'b0;
        endcase
    end

    // Control registers and prescaler level history
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            iccr    <= 8'd0;
            icmsk   <= 2'd0;
            presc_q <= 4'd0;
        end else begin
            presc_q <= {clk1024_i, clk256_i, clk64_i, clk8_i};
            if (wr_iccr) iccr <= bus_i & ICCR_WMASK;
            if (wr_icmsk) icmsk <= bus_i[1:0];
        end
    end

    // Counter (bus write beats clear-on-capture, which beats the tick) and capture register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            icnt <= 8'd0;
            icr  <= 8'd0;
        end else begin
            if (wr_icnt) begin
                icnt <= bus_i;
            end else if (ctc_clear) begin
                icnt <= 8'd0;
            end else if (count_tick) begin
                icnt <= icnt + 8'd1;
            end
            if (capture) icr <= icnt;
        end
    end

    // Flags: a hardware set in the same cycle wins over acknowledge or write-1-to-clear
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            icf <= 1'b0;
            tov <= 1'b0;
            ovr <= 1'b0;
        end else begin
            if (icf_set) icf <= 1'b1;
            else if (icf_clr) icf <= 1'b0;
            if (tov_set) tov <= 1'b1;
            else if (tov_clr) tov <= 1'b0;
            if (ovr_set) ovr <= 1'b1;
            else if (ovr_clr) ovr <= 1'b0;
        end
    end

    // Side-effect-free read mux, zero unless a read hits a register
    always_comb begin
        bus_o = 8'd0;
        if (rd_i) begin
            if (addr_i == ICCR_ADDR) bus_o = iccr;
            else if (addr_i == ICNT_ADDR) bus_o = icnt;
            else if (addr_i == ICR_ADDR) bus_o = icr;
            else if (addr_i == ICIFR_ADDR) bus_o = {5'd0, ovr, tov, icf};
            else if (addr_i == ICMSK_ADDR) bus_o = {6'd0, icmsk};
        end
    end

endmodule

// File: tb/tb_atmega_icp_8bit.sv
// Randomized bench for atmega_icp_8bit. Stimulus pushes expected bus reads and
// expected interrupt-assertion cycles into queues; a monitor pops and compares.
module tb_atmega_icp_8bit;
    import atmega_icp_8bit_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       clk8_i = 1'b0, clk64_i = 1'b0, clk256_i = 1'b0, clk1024_i = 1'b0;
    logic [7:0] addr_i = 8'd0;
    logic       wr_i = 1'b0, rd_i = 1'b0;
    logic [7:0] bus_i = 8'd0;
    logic [7:0] bus_o;
    logic       icp_int_o, tov_int_o;
    logic       icp_int_ack_i = 1'b0, tov_int_ack_i = 1'b0;
    logic       icp_i = 1'b1;

    atmega_icp_8bit dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .clk8_i(clk8_i), .clk64_i(clk64_i), .clk256_i(clk256_i), .clk1024_i(clk1024_i),
        .addr_i(addr_i), .wr_i(wr_i), .rd_i(rd_i), .bus_i(bus_i), .bus_o(bus_o),
        .icp_int_o(icp_int_o), .icp_int_ack_i(icp_int_ack_i),
        .tov_int_o(tov_int_o), .tov_int_ack_i(tov_int_ack_i),
        .icp_i(icp_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    int    cap_q[$];
    int    rd_exp_q[$];
    int    rd_mask_q[$];
    string rd_name_q[$];
    logic  icp_prev = 1'b0;

    // Reference counter: value after edge m is base_val plus elapsed edges when running
    logic [7:0] base_val = 8'd0;
    int         base_cyc = 0;
    bit         running = 1'b0;

    function automatic logic [7:0] cnt_at(input int m);
        if (running) return base_val + 8'(m - base_cyc);
        return base_val;
    endfunction

    // Scoreboard monitor: compares bus reads and interrupt assertion cycles
    always @(negedge clk_i) begin : monitor
        int         e, m, ec;
        string      n;
        logic [7:0] e8, m8;
        if (rd_i) begin
            checks++;
            if (rd_exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL read_unexpected: got %02h required no read", bus_o);
            end else begin
                e = rd_exp_q.pop_front();
                m = rd_mask_q.pop_front();
                n = rd_name_q.pop_front();
                e8 = e[7:0];
                m8 = m[7:0];
                if ((bus_o & m8) !== (e8 & m8)) begin
                    failures++;
                    $display("[TB] FAIL %s: got %02h required %02h (mask %02h) cycle %0d",
                             n, bus_o & m8, e8 & m8, m8, cyc);
                end
            end
        end
        if (icp_int_o && !icp_prev) begin
            checks++;
            if (cap_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL capture_unexpected: interrupt at cycle %0d required none", cyc);
            end else begin
                ec = cap_q.pop_front();
                if (cyc != ec) begin
                    failures++;
                    $display("[TB] FAIL capture_cycle: got %0d required %0d", cyc, ec);
                end
            end
        end
        icp_prev = icp_int_o;
    end

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        addr_i = a;
        bus_i  = d;
        wr_i   = 1'b1;
        step();
        wr_i   = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, input logic [7:0] e, input logic [7:0] m,
                            input string n);
        addr_i = a;
        rd_i   = 1'b1;
        rd_exp_q.push_back(int'(e));
        rd_mask_q.push_back(int'(m));
        rd_name_q.push_back(n);
        step();
        rd_i   = 1'b0;
    endtask

    task automatic set_icnt(input logic [7:0] v);
        bus_write(ICNT_ADDR_DEF, v);
        base_val = v;
        base_cyc = cyc;
    endtask

    task automatic set_iccr(input logic [7:0] v);
        bus_write(ICCR_ADDR_DEF, v);
        running = (v[2:0] == 3'b001);
    endtask

    task automatic icp_ack();
        icp_int_ack_i = 1'b1;
        step();
        icp_int_ack_i = 1'b0;
    endtask

    task automatic presc_pulse(input int which);
        if (which == 0) clk8_i = 1'b1; else clk64_i = 1'b1;
        step();
        clk8_i  = 1'b0;
        clk64_i = 1'b0;
        step();
    endtask

    task automatic check_output(input string n, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0b required %0b", n, act, exp);
        end
    endtask

    // Watchdog so a stuck run still terminates
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    // Main stimulus sequence
    initial begin : stimulus
        int         p, d, w, per;
        logic [7:0] v, v2, exp_icr;
        int         widths[5];
        int         periods[3];

        wait_cycles(3);
        rst_i = 1'b1;
        wait_cycles(20);
        $display("[TB] reset state");
        bus_read(ICCR_ADDR_DEF, 8'h00, 8'hFF, "reset_iccr");
        bus_read(ICNT_ADDR_DEF, 8'h00, 8'hFF, "reset_icnt");
        bus_read(ICR_ADDR_DEF, 8'h00, 8'hFF, "reset_icr");
        bus_read(ICIFR_ADDR_DEF, 8'h00, 8'hFF, "reset_icifr");
        bus_read(ICMSK_ADDR_DEF, 8'h00, 8'hFF, "reset_icmsk");
        check_output("reset_icp_int", icp_int_o, 1'b0);
        check_output("reset_tov_int", tov_int_o, 1'b0);

        $display("[TB] falling-edge capture, no filter");
        bus_write(ICMSK_ADDR_DEF, 8'h01);
        set_iccr(8'h01);
        for (int i = 0; i < 3; i++) begin
            d = $urandom_range(1, 20);
            v = (i == 0) ? 8'(8'h10 - d) : 8'($urandom_range(0, 255));
            set_icnt(v);
            bus_read(ICNT_ADDR_DEF, cnt_at(cyc), 8'hFF, "icnt_running");
            wait_cycles(d);
            p = cyc;
            icp_i = 1'b0;
            exp_icr = cnt_at(p + 2);
            cap_q.push_back(p + 3);
            wait_cycles(6);
            bus_read(ICR_ADDR_DEF, exp_icr, 8'hFF, "icr_fall");
            bus_read(ICIFR_ADDR_DEF, 8'h01, 8'h01, "icf_set_fall");
            icp_ack();
            bus_read(ICIFR_ADDR_DEF, 8'h00, 8'h01, "icf_after_ack");
            icp_i = 1'b1;
            wait_cycles(6);
        end
        bus_read(8'h55, 8'h00, 8'hFF, "unmapped_read");

        $display("[TB] noise canceller, rising edge");
        set_iccr(8'hC1);
        icp_i = 1'b0;
        wait_cycles(15);
        widths = '{3, 10, 0, 0, 4};
        widths[2] = $urandom_range(1, 3);
        widths[3] = $urandom_range(5, 12);
        for (int i = 0; i < 5; i++) begin
            w = widths[i];
            p = cyc;
            icp_i = 1'b1;
            exp_icr = cnt_at(p + 6);
            if (w >= 4) cap_q.push_back(p + 7);
            wait_cycles(w);
            icp_i = 1'b0;
            wait_cycles(15);
            if (w >= 4) begin
                bus_read(ICR_ADDR_DEF, exp_icr, 8'hFF, "icr_filtered");
                bus_read(ICIFR_ADDR_DEF, 8'h01, 8'h01, "icf_filtered");
                icp_ack();
            end else begin
                bus_read(ICIFR_ADDR_DEF, 8'h00, 8'h01, "icf_glitch");
            end
        end

        $display("[TB] clear-on-capture period measurement");
        set_iccr(8'h49);
        periods = '{50, 50, 0};
        periods[2] = $urandom_range(30, 200);
        p = cyc;
        icp_i = 1'b1;
        exp_icr = cnt_at(p + 2);
        cap_q.push_back(p + 3);
        base_val = 8'd0;
        base_cyc = p + 3;
        wait_until(p + 10);
        bus_read(ICR_ADDR_DEF, exp_icr, 8'hFF, "icr_ctc_first");
        icp_ack();
        wait_until(p + 20);
        icp_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            per = periods[i];
            wait_until(p + per);
            p = cyc;
            icp_i = 1'b1;
            exp_icr = cnt_at(p + 2);
            cap_q.push_back(p + 3);
            base_val = 8'd0;
            base_cyc = p + 3;
            wait_until(p + 10);
            bus_read(ICR_ADDR_DEF, exp_icr, 8'hFF, "icr_period");
            icp_ack();
            wait_until(p + 20);
            icp_i = 1'b0;
        end

        $display("[TB] overrun with stopped counter");
        set_iccr(8'h40);
        bus_write(ICIFR_ADDR_DEF, 8'h07);
        v = 8'($urandom_range(0, 255));
        set_icnt(v);
        p = cyc;
        icp_i = 1'b1;
        cap_q.push_back(p + 3);
        wait_cycles(8);
        bus_read(ICR_ADDR_DEF, v, 8'hFF, "icr_stopped");
        icp_i = 1'b0;
        wait_cycles(8);
        v2 = ~v;
        set_icnt(v2);
        wait_cycles(4);
        icp_i = 1'b1;
        wait_cycles(6);
        bus_read(ICR_ADDR_DEF, v2, 8'hFF, "icr_second");
        bus_read(ICIFR_ADDR_DEF, 8'h05, 8'hFF, "ovr_set");
        icp_ack();
        bus_read(ICIFR_ADDR_DEF, 8'h04, 8'hFF, "ovr_survives_ack");
        bus_write(ICR_ADDR_DEF, v);
        bus_read(ICR_ADDR_DEF, v2, 8'hFF, "icr_readonly");
        bus_write(ICIFR_ADDR_DEF, 8'h07);
        bus_read(ICIFR_ADDR_DEF, 8'h00, 8'hFF, "flags_cleared");

        $display("[TB] prescaled counting and overflow");
        set_iccr(8'h02);
        bus_write(ICMSK_ADDR_DEF, 8'h03);
        set_icnt(8'hFD);
        addr_i = ICNT_ADDR_DEF;
        rd_i = 1'b0;
        #1;
        checks++;
        if (bus_o !== 8'h00) begin
            failures++;
            $display("[TB] FAIL bus_idle: got %02h required 00", bus_o);
        end
        presc_pulse(0);
        presc_pulse(0);
        bus_read(ICNT_ADDR_DEF, 8'hFF, 8'hFF, "icnt_clk8");
        bus_read(ICIFR_ADDR_DEF, 8'h00, 8'h02, "tov_before_wrap");
        check_output("tov_int_before", tov_int_o, 1'b0);
        presc_pulse(0);
        bus_read(ICNT_ADDR_DEF, 8'h00, 8'hFF, "icnt_wrap");
        bus_read(ICIFR_ADDR_DEF, 8'h02, 8'hFF, "tov_on_wrap");
        check_output("tov_int_after", tov_int_o, 1'b1);
        set_icnt(8'hFF);
        clk8_i = 1'b1;
        tov_int_ack_i = 1'b1;
        step();
        clk8_i = 1'b0;
        tov_int_ack_i = 1'b0;
        step();
        bus_read(ICNT_ADDR_DEF, 8'h00, 8'hFF, "icnt_wrap2");
        bus_read(ICIFR_ADDR_DEF, 8'h02, 8'hFF, "tov_set_beats_ack");
        tov_int_ack_i = 1'b1;
        step();
        tov_int_ack_i = 1'b0;
        bus_read(ICIFR_ADDR_DEF, 8'h00, 8'hFF, "tov_acked");
        check_output("tov_int_acked", tov_int_o, 1'b0);
        set_iccr(8'h03);
        v = 8'($urandom_range(0, 200));
        set_icnt(v);
        repeat (3) presc_pulse(0);
        bus_read(ICNT_ADDR_DEF, v, 8'hFF, "clk8_ignored");
        presc_pulse(1);
        bus_read(ICNT_ADDR_DEF, 8'(v + 8'd1), 8'hFF, "icnt_clk64");

        $display("[TB] reset during capture");
        set_iccr(8'h01);
        p = cyc;
        icp_i = 1'b0;
        step();
        step();
        rst_i = 1'b0;
        wait_cycles(3);
        rst_i = 1'b1;
        running = 1'b0;
        base_val = 8'd0;
        wait_cycles(20);
        bus_read(ICR_ADDR_DEF, 8'h00, 8'hFF, "icr_after_reset");
        bus_read(ICIFR_ADDR_DEF, 8'h00, 8'hFF, "icifr_after_reset");
        bus_read(ICNT_ADDR_DEF, 8'h00, 8'hFF, "icnt_after_reset");
        bus_read(ICCR_ADDR_DEF, 8'h00, 8'hFF, "iccr_after_reset");
        check_output("icp_int_after_reset", icp_int_o, 1'b0);

        wait_cycles(10);
        checks++;
        if (cap_q.size() != 0 || rd_exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL queues_drained: got %0d captures %0d reads pending required 0",
                     cap_q.size(), rd_exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
